// File: rtl/pwm_ramp_if.sv
// Host write channel for pwm_ramp_ctrl: valid/ready handshake
// carrying a channel index and a new target duty.
interface pwm_ramp_if #(
  parameter int CH = 8,
  parameter int W  = 8
);
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  logic          wr_valid;
  logic          wr_ready;
  logic [IW-1:0] wr_ch;
  logic [W-1:0]  wr_duty;

  modport master (
    output wr_valid,
    output wr_ch,
    output wr_duty,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_ch,
    input  wr_duty,
    output wr_ready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Per-channel duty ramp controller: commits shadow duties on each
// PWM period boundary, then sweeps every shadow one step toward target.
module pwm_ramp_ctrl #(
  parameter int CH   = 8,
  parameter int W    = 8,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            period_end,
  pwm_ramp_if.slave       wr,
  output logic [CH*W-1:0] duty_out,
  output logic            at_target,
  output logic            overrun
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [W:0] STP = (W+1)'(STEP);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  target [CH];
  logic [W-1:0]  shadow [CH];
  logic          ch_ok;
  logic          wr_fire;
  logic          sweep;

  generate
    if (CH == (1 << IW)) begin : g_pow2
      assign ch_ok = 1'b1;
    end else begin : g_npow2
      assign ch_ok = {1'b0, wr.wr_ch} < (IW+1)'(CH);
    end
  endgenerate

  // Differences taken at W+1 bits so the step clamps at the target
  function automatic logic [W-1:0] step_to(
    input logic [W-1:0] cur,
    input logic [W-1:0] tgt
  );
    logic [W:0] d;
    logic [W:0] inc;
    d = '0;
    inc = '0;
    step_to = cur;
    if (cur < tgt) begin
      d = {1'b0, tgt} - {1'b0, cur};
      inc = (d < STP) ? d : STP;
      step_to = cur + inc[W-1:0];
    end else if (cur > tgt) begin
      d = {1'b0, cur} - {1'b0, tgt};
      inc = (d < STP) ? d : STP;
      step_to = cur - inc[W-1:0];
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr.wr_ready = 1'b0;
    sweep       = 1'b0;
    unique case (state_q)
      IDLE: begin
        wr.wr_ready = 1'b1;
        if (period_end) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        sweep = 1'b1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(CH-1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_fire = wr.wr_valid & wr.wr_ready & ch_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      overrun  <= 1'b0;
      duty_out <= '0;
      for (int k = 0; k < CH; k++) begin
        target[k] <= '0;
        shadow[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (wr_fire)
        target[wr.wr_ch] <= wr.wr_duty;
      // Commit sees the shadow before this cycle's sweep step
      if (period_end) begin
        for (int k = 0; k < CH; k++)
          duty_out[k*W +: W] <= shadow[k];
        if (state_q == SWEEP)
          overrun <= 1'b1;
      end
      if (sweep)
        shadow[idx_q] <= step_to(shadow[idx_q], target[idx_q]);
    end
  end

  always_comb begin
    at_target = 1'b1;
    for (int k = 0; k < CH; k++)
      if (duty_out[k*W +: W] != target[k])
        at_target = 1'b0;
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: STEP=1 and STEP=3 instances share stimulus
// and are compared against a per-period reference model.
module tb_pwm_ramp_ctrl;

  localparam int CH = 8;
  localparam int W  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pe = 1'b0;
  logic       valid = 1'b0;
  logic [2:0] wch = '0;
  logic [7:0] wduty = '0;

  logic [63:0] dout [2];
  logic        atg  [2];
  logic        ovr  [2];
  logic        rdy  [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_ramp_if #(.CH(CH), .W(W)) if1 ();
  pwm_ramp_if #(.CH(CH), .W(W)) if3 ();

  assign if1.wr_valid = valid;
  assign if1.wr_ch    = wch;
  assign if1.wr_duty  = wduty;
  assign if3.wr_valid = valid;
  assign if3.wr_ch    = wch;
  assign if3.wr_duty  = wduty;
  assign rdy[0] = if1.wr_ready;
  assign rdy[1] = if3.wr_ready;

  pwm_ramp_ctrl #(.CH(CH), .W(W), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .period_end(pe), .wr(if1.slave),
    .duty_out(dout[0]), .at_target(atg[0]), .overrun(ovr[0])
  );

  pwm_ramp_ctrl #(.CH(CH), .W(W), .STEP(3)) u_s3 (
    .clk(clk), .rst(rst), .period_end(pe), .wr(if3.slave),
    .duty_out(dout[1]), .at_target(atg[1]), .overrun(ovr[1])
  );

  // Reference model: m_since counts cycles since the last sweep start
  int m_tgt [2][CH];
  int m_shd [2][CH];
  int m_out [2][CH];
  int m_since [2] = '{CH, CH};
  bit m_ovr [2];

  function automatic int step_of(int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic int toward(int cur, int tgt, int s);
    if (cur < tgt) return cur + (((tgt - cur) < s) ? (tgt - cur) : s);
    if (cur > tgt) return cur - (((cur - tgt) < s) ? (cur - tgt) : s);
    return cur;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        m_since[m] = CH;
        m_ovr[m] = 1'b0;
        for (int k = 0; k < CH; k++) begin
          m_tgt[m][k] = 0;
          m_shd[m][k] = 0;
          m_out[m][k] = 0;
        end
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        int  pos;
        bit  idle;
        pos  = m_since[m];
        idle = (pos >= CH);
        if (valid && idle && int'(wch) < CH)
          m_tgt[m][wch] = int'(wduty);
        if (pe) begin
          for (int k = 0; k < CH; k++)
            m_out[m][k] = m_shd[m][k];
          if (!idle)
            m_ovr[m] = 1'b1;
        end
        if (!idle) begin
          m_shd[m][pos] = toward(m_shd[m][pos], m_tgt[m][pos], step_of(m));
          m_since[m] = pos + 1;
        end else if (pe) begin
          m_since[m] = 0;
        end
      end
    end
  end

  function automatic logic [63:0] m_pack(int m);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < CH; k++)
      v[k*8 +: 8] = 8'(m_out[m][k]);
    return v;
  endfunction

  function automatic bit m_at(int m);
    for (int k = 0; k < CH; k++)
      if (m_out[m][k] != m_tgt[m][k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("ready%0d", m), 64'(rdy[m]), 64'(m_since[m] >= CH));
      chk($sformatf("duty%0d", m), dout[m], m_pack(m));
      chk($sformatf("at_tgt%0d", m), 64'(atg[m]), 64'(m_at(m)));
      chk($sformatf("ovr%0d", m), 64'(ovr[m]), 64'(m_ovr[m]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && !rdy[0]; i++) tick();
    chk("idle_timeout", 64'(rdy[0]), 64'd1);
  endtask

  task automatic wr(input int c, input int d);
    valid = 1'b1;
    wch   = 3'(c);
    wduty = 8'(d);
    tick();
    valid = 1'b0;
  endtask

  task automatic pulse(input int gap);
    pe = 1'b1;
    tick();
    pe = 1'b0;
    repeat (gap - 1) tick();
  endtask

  int seq1 [6] = '{0, 1, 2, 3, 4, 4};
  int seq3 [6] = '{0, 3, 4, 4, 4, 4};
  int down3 [4] = '{7, 4, 1, 0};
  int lows;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_duty", dout[0] | dout[1], 64'd0);
    chk("rst_ready", 64'(rdy[0] & rdy[1]), 64'd1);
    chk("rst_at", 64'(atg[0] & atg[1]), 64'd1);
    chk("rst_ovr", 64'(ovr[0] | ovr[1]), 64'd0);
    tick();

    // Ramp up ch0 to 4, one pulse every 256 cycles
    wr(0, 4);
    for (int i = 0; i < 6; i++) begin
      pe = 1'b1;
      tick();
      pe = 1'b0;
      chk("up_s1", 64'(dout[0][7:0]), 64'(seq1[i]));
      chk("up_s3", 64'(dout[1][7:0]), 64'(seq3[i]));
      chk("up_others", dout[0][63:8], 64'd0);
      chk("up_at_s1", 64'(atg[0]), 64'(i >= 4));
      repeat (255) tick();
    end

    // Ramp down ch5 from 10 to 0
    wr(5, 10);
    repeat (5) pulse(20);
    wr(5, 0);
    pulse(20);
    for (int i = 0; i < 4; i++) begin
      pe = 1'b1;
      tick();
      pe = 1'b0;
      chk("down_s3", 64'(dout[1][47:40]), 64'(down3[i]));
      repeat (19) tick();
    end

    // Write stalled by a sweep
    wait_idle();
    pe = 1'b1;
    tick();
    pe = 1'b0;
    valid = 1'b1;
    wch = 3'd2;
    wduty = 8'd200;
    lows = 0;
    for (int i = 0; i < 40 && !rdy[0]; i++) begin
      lows++;
      tick();
    end
    tick();
    valid = 1'b0;
    chk("stall_lows", 64'(lows), 64'd8);

    // Write and period_end together in IDLE
    valid = 1'b1;
    wch = 3'd3;
    wduty = 8'd77;
    pe = 1'b1;
    tick();
    valid = 1'b0;
    pe = 1'b0;
    repeat (12) tick();
    pulse(12);
    chk("wrpe_s1", 64'(dout[0][31:24]), 64'd1);
    chk("wrpe_s3", 64'(dout[1][31:24]), 64'd3);

    // Overrun: two pulses 5 cycles apart
    wait_idle();
    for (int c = 0; c < CH; c++) wr(c, $urandom_range(20, 255));
    repeat (2) pulse(12);
    chk("ovr_pre", 64'(ovr[0] | ovr[1]), 64'd0);
    pulse(5);
    pulse(12);
    chk("ovr_set", 64'(ovr[0] & ovr[1]), 64'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      wch   = 3'($urandom);
      wduty = 8'($urandom);
      pe    = ($urandom_range(0, 19) == 0);
      tick();
    end
    valid = 1'b0;
    pe = 1'b0;
    chk("ovr_sticky", 64'(ovr[0] & ovr[1]), 64'd1);

    // Reset in the middle of a sweep
    wait_idle();
    wr(1, 255);
    pulse(12);
    pe = 1'b1;
    tick();
    pe = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("mid_duty", dout[0] | dout[1], 64'd0);
    chk("mid_ovr", 64'(ovr[0] | ovr[1]), 64'd0);
    check_all();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("mid_ready", 64'(rdy[0] & rdy[1]), 64'd1);
    chk("mid_at", 64'(atg[0] & atg[1]), 64'd1);
    pulse(12);
    pulse(12);
    chk("mid_tgt0", dout[0] | dout[1], 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Duty-cycle controller for the 8-channel `PWM_Gen` datapath. It holds a per-channel target duty written by a host, steps each channel's active duty toward its target by at most `STEP` once per PWM period, and presents the duty values to the generator. Commits happen only on the generator's period boundary, so no channel ever changes duty mid-period.

## Interface
- `CH`, 8: number of PWM channels; matches `pwm[7:0]`.
- `W`, 8: duty width in bits; duty value d gives d/2^W high time.
- `STEP`, 1: maximum duty change per period per channel; legal range 1..2^W-1.
- `clk` in, 1: single clock; all logic on rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `period_end` in, 1: one-cycle pulse from `PWM_Gen` on the last cycle of each PWM period.
- `wr_valid` in, 1: host write request.
- `wr_ready` out, 1: write accepted when `wr_valid & wr_ready`.
- `wr_ch` in, 3 (clog2 CH): channel index of write.
- `wr_duty` in, W: new target duty.
- `duty_out` out, CH*W: committed duty; channel k at bits [k*W +: W]; drives `PWM_Gen`.
- `at_target` out, 1: combinational; high when every `duty_out` channel equals its target.
- `overrun` out, 1: sticky; set when `period_end` arrives during a sweep.

## Operation
- Three register arrays per channel: `target`, `shadow` (next duty), `duty_out` (committed duty).
- FSM states: IDLE and SWEEP; 3-bit `idx`.
- IDLE: `wr_ready`=1. An accepted write sets `target[wr_ch]` <= `wr_duty`. On `period_end`: `duty_out` <= `shadow` (all channels, atomically), `idx` <= 0, state <= SWEEP.
- SWEEP: `wr_ready`=0. Each cycle, `shadow[idx]` steps toward `target[idx]`, then `idx` increments. After `idx`==CH-1, state <= IDLE.
- Step rule: if cur<tgt, cur + min(STEP, tgt-cur). If cur>tgt, cur - min(STEP, cur-tgt). If equal, hold. Compute differences at W+1 bits. The result never overshoots, wraps or saturates past the target.
- Write and `period_end` in the same IDLE cycle: both are taken. The new target is visible to the sweep that starts next cycle.
- `period_end` in SWEEP:
  - `duty_out` <= `shadow` still commits, using the partially updated shadow.
  - The sweep continues without restarting.
  - `overrun` <= 1.
- `overrun` clears only on reset.
- Out-of-range `wr_ch` (CH not a power of 2): the write is accepted and ignored.

## Timing
- Reset values, all asynchronous: `target`=0, `shadow`=0, `duty_out`=0, state IDLE, `idx`=0, `wr_ready`=1, `overrun`=0, `at_target`=1.
- `period_end` sampled at edge T:
  - `duty_out` updates at edge T.
  - `shadow[k]` updates at edge T+1+k.
  - State returns to IDLE after edge T+CH.
  - `wr_ready` is low for exactly CH cycles.
- A target written before period n's `period_end` first reaches `duty_out` at period n+1's `period_end`. Latency is one full period plus one step.
- A ramp of distance D takes ceil(D/STEP) periods after that first commit.
- Minimum period without overrun: CH+1 clk cycles.
- Reset asserted mid-sweep aborts immediately. Outputs return to reset values and `duty_out` reads 0 the same cycle.

## Test plan
- Reset: assert `rst` for 3 cycles. All `duty_out` = 0, `wr_ready`=1, `overrun`=0, `at_target`=1.
- Ramp up, STEP=1: write ch0=4, then `period_end` every 256 cycles. ch0 `duty_out` reads 0,1,2,3,4 after successive pulses, then holds. Other channels stay 0. `at_target` rises on the 5th commit.
- Ramp down, STEP=3: preload ch5 to 10 and let it settle. Write ch5=0. Successive commits give 7,4,1,0, with no underflow.
- Write stall: hold `wr_valid` with ch2=200 starting 1 cycle after `period_end`. `wr_ready` is low for 8 cycles and the write is accepted on the 9th. The write plus a simultaneous `period_end` in IDLE is also accepted.
- Overrun: pulse `period_end` 5 cycles apart. `overrun`=1 and stays set. The second commit holds ch0..3 stepped and ch4..7 unstepped.
- Reset mid-sweep: assert `rst` 3 cycles after `period_end` while ramping ch1 toward 255. `duty_out`=0 immediately, the FSM is IDLE after release, and the target is 0.
